// File: rtl/pll_reconfig_ctrl.sv
// pll_reconfig_ctrl: runtime M-counter reconfiguration for the hasher PLL.
// Runs on the oscillator clock; rebuilds the scan chain, shifts it, relocks.

module pll_reconfig_ctrl #(
  parameter int                   CHAIN_LEN  = 144,
  parameter logic [CHAIN_LEN-1:0] CHAIN_BASE = '0,
  parameter int                   M_POS      = 36,
  parameter int                   MULT_MIN   = 2,
  parameter int                   MULT_MAX   = 120,
  parameter int                   SCAN_DIV   = 2,
  parameter int                   AR_CYCLES  = 16,
  parameter int                   LOCK_FILT  = 1024,
  parameter int                   TIMEOUT    = 65535
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       req_valid,
  input  logic [7:0] req_mult,
  output logic       req_ready,
  output logic       resp_done,
  output logic       resp_err,
  output logic [7:0] cur_mult,
  output logic       pll_scanclk,
  output logic       pll_scanclkena,
  output logic       pll_scandata,
  output logic       pll_configupdate,
  input  logic       pll_scandone,
  output logic       pll_areset,
  input  logic       pll_locked,
  output logic       clk_ok,
  output logic [7:0] lock_loss_cnt
);

  localparam int BW = $clog2(CHAIN_LEN + 1);
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int AW = (AR_CYCLES > 1) ? $clog2(AR_CYCLES) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int LW = $clog2(LOCK_FILT + 1);

  localparam logic [BW-1:0] BIT_END = BW'(CHAIN_LEN);
  localparam logic [DW-1:0] DIV_END = DW'(SCAN_DIV - 1);
  localparam logic [AW-1:0] AR_END  = AW'(AR_CYCLES - 1);
  localparam logic [TW-1:0] TO_END  = TW'(TIMEOUT);
  localparam logic [LW-1:0] LF_END  = LW'(LOCK_FILT);
  localparam logic [7:0]    MIN8    = 8'(MULT_MIN);
  localparam logic [7:0]    MAX8    = 8'(MULT_MAX);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOAD      = 3'd1;
  localparam logic [2:0] S_SHIFT     = 3'd2;
  localparam logic [2:0] S_UPDATE    = 3'd3;
  localparam logic [2:0] S_WAIT_DONE = 3'd4;
  localparam logic [2:0] S_RESET_PLL = 3'd5;
  localparam logic [2:0] S_WAIT_LOCK = 3'd6;

  logic [2:0]           state;
  logic [CHAIN_LEN-1:0] sreg;
  logic [CHAIN_LEN-1:0] chain;
  logic [17:0]          m_field;
  logic [8:0]           hi9;
  logic [7:0]           mult_q;
  logic                 fail_q;
  logic [DW-1:0]        div_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [AW-1:0]        ar_cnt;
  logic [TW-1:0]        tcnt;
  logic [LW-1:0]        lcnt;
  logic                 done_m, done_s, done_d;
  logic                 lock_m, lock_s, lock_d;
  logic                 done_rise;
  logic                 lock_fall;
  logic                 filt_ok;
  logic                 mon_en;
  logic                 mult_bad;

  assign req_ready    = (state == S_IDLE);
  assign pll_scandata = sreg[CHAIN_LEN-1];
  assign done_rise    = done_s & ~done_d;
  assign lock_fall    = lock_d & ~lock_s;
  assign filt_ok      = (lcnt == LF_END);
  assign mon_en       = (state == S_IDLE) || (state == S_WAIT_LOCK);
  assign mult_bad     = (req_mult < MIN8) || (req_mult > MAX8);

  // Chain image: fixed fields plus the M field {bypass, hi, odd, lo}
  always_comb begin
    hi9     = {1'b0, mult_q} + 9'd1;
    m_field = {1'b0, hi9[8:1], mult_q[0], 1'b0, mult_q[7:1]};
    chain   = CHAIN_BASE;
    chain[M_POS +: 18] = m_field;
  end

  // Two-flop synchronisers plus one delay stage for edge detection
  always_ff @(posedge clk) begin
    if (!rstn) begin
      {done_m, done_s, done_d} <= '0;
      {lock_m, lock_s, lock_d} <= '0;
    end else begin
      done_m <= pll_scandone;
      done_s <= done_m;
      done_d <= done_s;
      lock_m <= pll_locked;
      lock_s <= lock_m;
      lock_d <= lock_s;
    end
  end

  // Lock filter: run length of synced lock, only while monitoring
  always_ff @(posedge clk) begin
    if (!rstn) begin
      lcnt <= '0;
    end else if (!lock_s || !mon_en) begin
      lcnt <= '0;
    end else if (lcnt != LF_END) begin
      lcnt <= lcnt + 1'b1;
    end
  end

  // Reconfiguration sequencer, scan clock generator and lock monitor
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state            <= S_IDLE;
      sreg             <= '0;
      mult_q           <= '0;
      fail_q           <= 1'b0;
      div_cnt          <= '0;
      bit_cnt          <= '0;
      ar_cnt           <= '0;
      tcnt             <= '0;
      resp_done        <= 1'b0;
      resp_err         <= 1'b0;
      cur_mult         <= '0;
      pll_scanclk      <= 1'b0;
      pll_scanclkena   <= 1'b0;
      pll_configupdate <= 1'b0;
      pll_areset       <= 1'b0;
      clk_ok           <= 1'b0;
      lock_loss_cnt    <= '0;
    end else begin
      resp_done <= 1'b0;
      resp_err  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (lock_fall) begin
            clk_ok <= 1'b0;
            if (lock_loss_cnt != 8'hFF)
              lock_loss_cnt <= lock_loss_cnt + 8'd1;
          end else if (filt_ok) begin
            clk_ok <= 1'b1;
          end
          if (req_valid) begin
            if (mult_bad) begin
              resp_err <= 1'b1;
            end else begin
              mult_q <= req_mult;
              state  <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          sreg           <= chain;
          fail_q         <= 1'b0;
          div_cnt        <= '0;
          bit_cnt        <= '0;
          pll_scanclk    <= 1'b0;
          pll_scanclkena <= 1'b1;
          clk_ok         <= 1'b0;
          state          <= S_SHIFT;
        end
        S_SHIFT: begin
          if (div_cnt == DIV_END) begin
            div_cnt     <= '0;
            pll_scanclk <= ~pll_scanclk;
            if (!pll_scanclk) begin
              bit_cnt <= bit_cnt + 1'b1;
            end else if (bit_cnt == BIT_END) begin
              sreg             <= '0;
              pll_scanclkena   <= 1'b0;
              pll_configupdate <= 1'b1;
              state            <= S_UPDATE;
            end else begin
              sreg <= {sreg[CHAIN_LEN-2:0], 1'b0};
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        S_UPDATE: begin
          if (div_cnt == DIV_END) begin
            div_cnt     <= '0;
            pll_scanclk <= ~pll_scanclk;
            if (pll_scanclk) begin
              pll_configupdate <= 1'b0;
              tcnt             <= '0;
              state            <= S_WAIT_DONE;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (done_rise || tcnt == TO_END) begin
            if (!done_rise) begin
              resp_err <= 1'b1;
              fail_q   <= 1'b1;
            end
            pll_areset <= 1'b1;
            ar_cnt     <= '0;
            state      <= S_RESET_PLL;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_RESET_PLL: begin
          if (ar_cnt == AR_END) begin
            pll_areset <= 1'b0;
            tcnt       <= '0;
            state      <= S_WAIT_LOCK;
          end else begin
            ar_cnt <= ar_cnt + 1'b1;
          end
        end
        S_WAIT_LOCK: begin
          if (filt_ok) begin
            clk_ok <= 1'b1;
            state  <= S_IDLE;
            if (!fail_q) begin
              cur_mult  <= mult_q;
              resp_done <= 1'b1;
            end
          end else if (tcnt == TO_END) begin
            resp_err <= ~fail_q;
            state    <= S_IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// tb_pll_reconfig_ctrl: directed scoreboard bench for pll_reconfig_ctrl.
// Models scandone/locked, checks serialized chain bits and responses.

module tb_pll_reconfig_ctrl;

  localparam int CL  = 144;
  localparam int MP  = 36;
  localparam int LF  = 64;
  localparam int TO  = 1000;
  localparam int ARC = 16;
  localparam logic [CL-1:0] BASE = {9{16'hC3A5}};

  typedef struct packed {
    logic       is_err;
    logic [7:0] mult;
  } exp_t;

  logic       clk;
  logic       rstn;
  logic       req_valid;
  logic [7:0] req_mult;
  logic       req_ready;
  logic       resp_done;
  logic       resp_err;
  logic [7:0] cur_mult;
  logic       pll_scanclk;
  logic       pll_scanclkena;
  logic       pll_scandata;
  logic       pll_configupdate;
  logic       pll_scandone;
  logic       pll_areset;
  logic       pll_locked;
  logic       clk_ok;
  logic [7:0] lock_loss_cnt;

  pll_reconfig_ctrl #(
    .CHAIN_LEN (CL),
    .CHAIN_BASE(BASE),
    .M_POS     (MP),
    .MULT_MIN  (2),
    .MULT_MAX  (120),
    .SCAN_DIV  (2),
    .AR_CYCLES (ARC),
    .LOCK_FILT (LF),
    .TIMEOUT   (TO)
  ) dut (
    .clk             (clk),
    .rstn            (rstn),
    .req_valid       (req_valid),
    .req_mult        (req_mult),
    .req_ready       (req_ready),
    .resp_done       (resp_done),
    .resp_err        (resp_err),
    .cur_mult        (cur_mult),
    .pll_scanclk     (pll_scanclk),
    .pll_scanclkena  (pll_scanclkena),
    .pll_scandata    (pll_scandata),
    .pll_configupdate(pll_configupdate),
    .pll_scandone    (pll_scandone),
    .pll_areset      (pll_areset),
    .pll_locked      (pll_locked),
    .clk_ok          (clk_ok),
    .lock_loss_cnt   (lock_loss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  logic bit_q[$];
  int   resp_cnt = 0;
  int   rises, cfg_pulses, cfg_len, ar_len, sd_viol, any_pll;
  logic sclk_prev = 1'b0;
  logic cfg_prev = 1'b0;
  logic sd_prev = 1'b0;
  logic scan_chk = 1'b1;
  logic done_en = 1'b1;
  int   done_dly = 0;
  int   relock_dly = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [CL-1:0] build(input int m);
    logic [CL-1:0] c;
    int lo, hi;
    c  = BASE;
    lo = m / 2;
    hi = (m + 1) / 2;
    for (int i = 0; i < 8; i++) begin
      c[MP + i]     = lo[i];
      c[MP + 9 + i] = hi[i];
    end
    c[MP + 8]  = 1'(m % 2);
    c[MP + 17] = 1'b0;
    return c;
  endfunction

  // One clock: sample DUT, run scoreboard and the PLL model
  task automatic tick();
    exp_t e;
    logic b;
    @(posedge clk);
    #1;
    if (pll_scanclk && !sclk_prev && pll_scanclkena) begin
      rises++;
      if (scan_chk) begin
        if (bit_q.size() == 0) begin
          chk("scan_extra", 32'd1, 32'd0);
        end else begin
          b = bit_q.pop_front();
          chk("scan_bit", 32'(pll_scandata), 32'(b));
        end
      end
    end
    if (pll_scandata != sd_prev && pll_scanclk) sd_viol++;
    if (pll_configupdate && !cfg_prev) cfg_pulses++;
    if (pll_configupdate) cfg_len++;
    if (pll_areset) ar_len++;
    if (pll_scanclk || pll_scanclkena || pll_scandata ||
        pll_configupdate || pll_areset) any_pll++;
    if (resp_done || resp_err) begin
      resp_cnt++;
      if (exp_q.size() == 0) begin
        chk("resp_unexpected", {30'd0, resp_done, resp_err}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("resp_kind", {30'd0, resp_done, resp_err},
            e.is_err ? 32'd1 : 32'd2);
        if (!e.is_err) begin
          chk("cur_mult_done", 32'(cur_mult), 32'(e.mult));
          chk("clk_ok_done", 32'(clk_ok), 32'd1);
        end
      end
    end
    if (pll_scanclkena) pll_scandone = 1'b0;
    if (cfg_prev && !pll_configupdate && done_en) done_dly = 3;
    if (done_dly > 0) begin
      done_dly--;
      if (done_dly == 0) pll_scandone = 1'b1;
    end
    if (pll_areset) begin
      pll_locked = 1'b0;
      relock_dly = 20;
    end else if (relock_dly > 0) begin
      relock_dly--;
      if (relock_dly == 0) pll_locked = 1'b1;
    end
    sclk_prev = pll_scanclk;
    cfg_prev  = pll_configupdate;
    sd_prev   = pll_scandata;
  endtask

  task automatic clr_op();
    rises = 0; cfg_pulses = 0; cfg_len = 0;
    ar_len = 0; sd_viol = 0; any_pll = 0;
  endtask

  task automatic wait_ready(input int budget);
    int n;
    n = 0;
    while (!req_ready && n < budget) begin
      tick();
      n++;
    end
    chk("ready_wait", 32'(req_ready), 32'd1);
  endtask

  task automatic do_req(input int m, input logic exp_err);
    exp_t e;
    logic [CL-1:0] c;
    logic legal;
    legal = (m >= 2) && (m <= 120);
    wait_ready(5000);
    clr_op();
    if (legal && scan_chk) begin
      c = build(m);
      for (int i = CL - 1; i >= 0; i--) bit_q.push_back(c[i]);
    end
    e.is_err = exp_err || !legal;
    e.mult   = 8'(m);
    exp_q.push_back(e);
    req_valid = 1'b1;
    req_mult  = 8'(m);
    tick();
    req_valid = 1'b0;
    if (legal) begin
      chk("ready_busy", 32'(req_ready), 32'd0);
      chk("ena_load", 32'(pll_scanclkena), 32'd0);
      tick();
      chk("ena_shift", 32'(pll_scanclkena), 32'd1);
    end else begin
      chk("err_lat", 32'(resp_err), 32'd1);
      chk("ready_idle", 32'(req_ready), 32'd1);
    end
  endtask

  task automatic wait_resp(input int budget);
    int n0, n;
    n0 = resp_cnt;
    n  = 0;
    while (resp_cnt == n0 && n < budget) begin
      tick();
      n++;
    end
    chk("resp_arrived", 32'(resp_cnt != n0), 32'd1);
  endtask

  task automatic end_op(input int m);
    chk("scan_rises", 32'(rises), CL);
    chk("cfg_pulses", 32'(cfg_pulses), 32'd1);
    chk("cfg_len", 32'(cfg_len), 32'd4);
    chk("areset_len", 32'(ar_len), ARC);
    chk("bits_left", 32'(bit_q.size()), 32'd0);
    chk("sd_stable", 32'(sd_viol), 32'd0);
    chk("cur_mult", 32'(cur_mult), 32'(m));
    chk("clk_ok", 32'(clk_ok), 32'd1);
  endtask

  logic [24:0] rst_vec;
  int          n;

  assign rst_vec = {req_ready, resp_done, resp_err, cur_mult, clk_ok,
                    lock_loss_cnt, pll_scanclk, pll_scanclkena,
                    pll_scandata, pll_configupdate, pll_areset};

  initial begin
    rstn         = 1'b0;
    req_valid    = 1'b0;
    req_mult     = 8'd0;
    pll_scandone = 1'b0;
    pll_locked   = 1'b1;
    clr_op();
    repeat (3) tick();
    chk("reset_vec", 32'(rst_vec), 32'h100_0000);
    rstn = 1'b1;
    tick();
    chk("ok_after_rst", 32'(clk_ok), 32'd0);
    n = 0;
    while (!clk_ok && n < 4 * LF) begin
      tick();
      n++;
    end
    chk("poweron_ok", 32'(clk_ok && n >= LF), 32'd1);
    chk("cur_mult_po", 32'(cur_mult), 32'd0);

    do_req(100, 1'b0);
    wait_resp(3000);
    end_op(100);

    do_req(101, 1'b0);
    wait_resp(3000);
    end_op(101);

    do_req(120, 1'b0);
    wait_resp(3000);
    end_op(120);

    do_req(1, 1'b0);
    repeat (3) tick();
    do_req(121, 1'b0);
    repeat (3) tick();
    chk("bad_no_pll", 32'(any_pll), 32'd0);
    chk("bad_q_empty", 32'(exp_q.size()), 32'd0);
    chk("bad_ready", 32'(req_ready), 32'd1);
    chk("bad_cur", 32'(cur_mult), 32'd120);

    done_en = 1'b0;
    do_req(50, 1'b1);
    wait_resp(CL * 4 + TO + 200);
    wait_ready(500);
    done_en = 1'b1;
    chk("to_areset", 32'(ar_len), ARC);
    chk("to_cfg", 32'(cfg_pulses), 32'd1);
    chk("to_cur", 32'(cur_mult), 32'd120);
    repeat (5) tick();
    chk("to_q_empty", 32'(exp_q.size()), 32'd0);

    for (int k = 0; k < 3; k++) begin
      pll_locked = 1'b0;
      repeat (6) tick();
      chk("glitch_drop", 32'(clk_ok), 32'd0);
      pll_locked = 1'b1;
      n = 0;
      while (!clk_ok && n < 3 * LF) begin
        tick();
        n++;
      end
      chk("relock_hold", 32'(clk_ok && n >= LF), 32'd1);
    end
    chk("loss_cnt", 32'(lock_loss_cnt), 32'd3);

    scan_chk = 1'b0;
    clr_op();
    req_valid = 1'b1;
    req_mult  = 8'd80;
    tick();
    req_valid = 1'b0;
    repeat (200) tick();
    chk("mid_shift", 32'(pll_scanclkena), 32'd1);
    rstn = 1'b0;
    tick();
    chk("abort_vec", 32'(rst_vec), 32'h100_0000);
    tick();
    rstn = 1'b1;
    chk("abort_cfg", 32'(cfg_pulses), 32'd0);
    scan_chk = 1'b1;
    do_req(64, 1'b0);
    wait_resp(3000);
    end_op(64);
    chk("final_q", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pll_reconfig_ctrl.md
# pll_reconfig_ctrl

Runtime frequency controller for the hasher PLL (Cyclone IV E `altpll`, scan-chain reconfiguration enabled). It accepts a requested multiply value from the serial command path and rebuilds the PLL scan chain with the new M-counter settings. It then shifts the chain in, triggers `configupdate`, resets the PLL and qualifies lock. It runs on the raw oscillator clock (the PLL input clock), never on the PLL output, and publishes a qualified clock-good flag that gates the hashers.

## Interface
Parameters:
- CHAIN_LEN, 144: scan chain length in bits.
- CHAIN_BASE, 144'h0: fixed chain image (all non-M fields).
- M_POS, 36: bit index of the M-field LSB within the chain.
- MULT_MIN, 2: lowest legal multiply value.
- MULT_MAX, 120: highest legal multiply value.
- SCAN_DIV, 2: clk cycles per scanclk half-period.
- AR_CYCLES, 16: pll_areset pulse length in clk cycles.
- LOCK_FILT, 1024: clk cycles locked must stay high to qualify.
- TIMEOUT, 65535: wait limit in clk cycles for scandone and for lock.

Ports:
- clk  in  1  oscillator clock (PLL inclk0).
- rstn  in  1  synchronous, active-low reset.
- req_valid  in  1  new multiply request.
- req_mult  in  8  requested M value.
- req_ready  out  1  high in IDLE only.
- resp_done  out  1  one-cycle pulse: reconfiguration done and lock qualified.
- resp_err  out  1  one-cycle pulse: request rejected or timeout.
- cur_mult  out  8  last successfully applied M.
- pll_scanclk  out  1  scan clock.
- pll_scanclkena  out  1  scan clock enable.
- pll_scandata  out  1  serial chain data.
- pll_configupdate  out  1  configuration update strobe.
- pll_scandone  in  1  asynchronous; synchronised internally.
- pll_areset  out  1  PLL reset.
- pll_locked  in  1  asynchronous; synchronised internally.
- clk_ok  out  1  PLL locked and filtered.
- lock_loss_cnt  out  8  saturating count of lock-loss events.

## Operation
- The M field is 18 bits at M_POS, LSB first upward: lo[7:0], odd, hi[7:0], bypass.
  - hi = (mult+1)>>1.
  - lo = mult>>1.
  - odd = mult[0].
  - bypass = 0.
- The chain is CHAIN_BASE with the M field overwritten. It is shifted MSB first (bit CHAIN_LEN-1 first).
- The request is accepted when req_valid && req_ready. req_mult is captured.
- If req_mult < MULT_MIN or req_mult > MULT_MAX, resp_err pulses on the next cycle, the block stays in IDLE, and nothing is driven to the PLL.
- FSM states:
  - IDLE: on a legal request, go to LOAD.
  - LOAD (1 cycle): build the chain into a shift register. Clear clk_ok. Go to SHIFT.
  - SHIFT: pll_scanclkena=1. pll_scandata changes only while scanclk is low. After CHAIN_LEN scanclk rising edges, go to UPDATE.
  - UPDATE: pll_configupdate=1 for exactly one scanclk period, from falling edge to falling edge. Go to WAIT_DONE.
  - WAIT_DONE: wait for the synced scandone rise. On timeout: resp_err, go to RESET_PLL.
  - RESET_PLL: pll_areset=1 for AR_CYCLES. Go to WAIT_LOCK.
  - WAIT_LOCK: wait until synced locked has been continuously high for LOCK_FILT cycles. Then set cur_mult=captured value, pulse resp_done, set clk_ok=1, go to IDLE. On timeout: resp_err, go to IDLE, cur_mult unchanged.
- Lock monitor, active in IDLE only:
  - A synced locked falling edge clears clk_ok and increments lock_loss_cnt, saturating at 255.
  - clk_ok returns to 1 after LOCK_FILT continuous locked cycles.
- After reset, the lock monitor qualifies lock against the power-on PLL configuration. cur_mult resets to 0, meaning "power-on value".

## Timing
- Reset values:
  - req_ready=1.
  - resp_done=0, resp_err=0.
  - cur_mult=0.
  - clk_ok=0.
  - lock_loss_cnt=0.
  - All pll_* outputs 0.
  - scanclk low.
- Input synchronisers are 2-flop. Synced-signal latency is 2 cycles.
- Scan period is 2*SCAN_DIV cycles. SHIFT lasts CHAIN_LEN*2*SCAN_DIV cycles; at defaults that is 576 cycles.
- Latency from accept to entering SHIFT is 2 cycles.
- Requests arriving while not in IDLE are not accepted. req_ready=0, and the source holds its request.
- rstn low in any state aborts immediately to reset values. pll_areset drops, and a partially shifted chain is abandoned. No configupdate is issued unless UPDATE had already been reached.
- resp_done and resp_err are never high in the same cycle.
- Both timeout counters saturate at TIMEOUT.

## Test plan
- Legal request, req_mult=100 → chain M field: hi=50, lo=50, odd=0. Exactly 144 scanclk rises, then one configupdate pulse. Model scandone and locked → resp_done, cur_mult=100, clk_ok=1.
- req_mult=101 → hi=51, lo=50, odd=1. Check the serialized bits MSB first against the bench-built image.
- req_mult=1, then req_mult=121 → resp_err each, one cycle after accept. No pll_* activity. req_ready stays 1.
- scandone held low → resp_err after TIMEOUT. areset pulse of 16 cycles still issued. cur_mult unchanged.
- Locked glitches low 3 times in IDLE → lock_loss_cnt=3. clk_ok low for ≥LOCK_FILT cycles after each recovery.
- rstn asserted midway through SHIFT → all outputs at reset values next cycle. A new request afterwards completes normally.
